alu_exec_unit: RTL

- Parametrised, registered successor of the combinational ALU-control + ALU pair in the pipeline's EX stage.
- Decodes ALUop/funct internally and registers the result with a valid/ready handshake.
- Adds unsigned multiply (iterative shift-add) into HI/LO registers, plus MFHI/MFLO read-back.
- Sits between ID/EX and EX/MEM; stalls upstream while busy or while the output is blocked.

---
 rtl/alu_defs_pkg.sv | 35 +++
 rtl/alu_op_decode.sv | 41 ++++
 rtl/alu_exec_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_defs_pkg.sv
// Shared encodings for the EX-stage execute unit: ALUop codes, R-type
// funct codes and the internal operation enum produced by the decoder.
package alu_defs_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_NOR,
        OP_SLT,
        OP_SLTU,
        OP_MULTU,
        OP_MFHI,
        OP_MFLO,
        OP_ILL
    } op_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUop/funct decoder. When the multiplier is not built,
// multu/mfhi/mflo collapse onto the illegal operation.
module alu_op_decode
    import alu_defs_pkg::*;
#(
    parameter int MUL_EN = 1
) (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output op_t        op
);

    localparam bit HAS_MUL = (MUL_EN != 0);

    // Map the two-level opcode onto a single internal operation.
    always_comb begin
        // NOTE: default assigned first so every path drives op -- no latch.
        op = OP_ILL;
        unique case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_OR:  op = OP_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:   op = OP_ADD;
                    FUNCT_SUB:   op = OP_SUB;
                    FUNCT_AND:   op = OP_AND;
                    FUNCT_OR:    op = OP_OR;
                    FUNCT_NOR:   op = OP_NOR;
                    FUNCT_SLT:   op = OP_SLT;
                    FUNCT_SLTU:  op = OP_SLTU;
                    FUNCT_MULTU: op = HAS_MUL ? OP_MULTU : OP_ILL;
                    FUNCT_MFHI:  op = HAS_MUL ? OP_MFHI  : OP_ILL;
                    FUNCT_MFLO:  op = HAS_MUL ? OP_MFLO  : OP_ILL;
                    default:     op = OP_ILL;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered EX-stage ALU with valid/ready handshake, iterative unsigned
// shift-add multiplier into HI/LO and MFHI/MFLO read-back.
module alu_exec_unit
    import alu_defs_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carryout,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {ST_IDLE, ST_MUL} mul_state_t;

    op_t                op;
    mul_state_t         state, state_next;
    logic               accept, start_mul, mul_done;
    logic [WIDTH-1:0]   hi, lo, mplier;
    logic [2*WIDTH-1:0] mcand, acc, acc_step;
    logic [CW-1:0]      count;

    logic               sub_sel;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     add_full;
    logic               add_ovf;
    logic [WIDTH-1:0]   res_d;
    logic               carry_d, ovf_d, ill_d;

    alu_op_decode #(.MUL_EN(MUL_EN)) u_decode (
        .alu_op (alu_op),
        .funct  (funct),
        .op     (op)
    );

    assign busy      = (state == ST_MUL);
    assign in_ready  = !busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (op == OP_MULTU);
    assign mul_done  = busy && (count == CW'(WIDTH - 1));

    // Shared adder: subtract is a + ~b + 1, carry of 1 means no borrow.
    assign sub_sel  = (op == OP_SUB);
    assign b_eff    = sub_sel ? ~b : b;
    assign add_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    assign add_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (add_full[WIDTH-1] != a[WIDTH-1]);

    // One shift-add step: add the shifted multiplicand when the low multiplier bit is set.
    assign acc_step = acc + (mplier[0] ? mcand : '0);

    // Result and flags for every single-cycle operation.
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        ill_d   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_d   = add_full[WIDTH-1:0];
                carry_d = add_full[WIDTH];
                ovf_d   = add_ovf;
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_NOR:  res_d = ~(a | b);
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: res_d = hi;
            OP_MFLO: res_d = lo;
            OP_ILL:  ill_d = 1'b1;
            default: res_d = '0;
        endcase
    end

    // Multiplier state register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) on all flops so each samples pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Multiplier next state: leave IDLE on a multu accept, return after the last step.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Multiplier datapath and HI/LO; reset also aborts an in-flight multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (start_mul) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (busy) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (mul_done) {hi, lo} <= acc_step;
        end
    end

    // Output register: load on accept or multiply completion, clear when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !start_mul) begin
            out_valid <= 1'b1;
            result    <= res_d;
            zero      <= (res_d == '0);
            carryout  <= carry_d;
            overflow  <= ovf_d;
            illegal   <= ill_d;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= '0;
            zero      <= 1'b1;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
